// File: rtl/sr_mon_pkg.sv
// ============================================================================
// Package  : sr_mon_pkg
// Purpose  : Shared state encoding and default sizes for the SR latch monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_mon_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } mon_state_t;

    localparam int SYNC_STAGES   = 2;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_DB_CYCLES = 4;
    // Debounce counter width covers the full legal DB_CYCLES range (2..255).
    localparam int DBC_W         = 8;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit flop-chain synchroniser, asynchronous active-low reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff
    import sr_mon_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/sr_latch_monitor.sv
// ============================================================================
// Module   : sr_latch_monitor
// Purpose  : Synchronises, debounces and validates NAND SR latch Q/Qbar,
//            producing a clean level, edge pulses and saturating event counts.
// Options  : define SR_MON_FALL_COUNT_EN to add the reset_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_monitor
    import sr_mon_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q_async,
    input  logic             qbar_async,
    input  logic             clr,
    output logic             q_clean,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             invalid,
    output logic [CNT_W-1:0] set_count
`ifdef SR_MON_FALL_COUNT_EN
    ,
    output logic [CNT_W-1:0] reset_count
`endif
);

    localparam logic [DBC_W-1:0] C_DBC_LAST = DBC_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    logic             w_q_s;
    logic             w_qbar_s;
    logic             w_valid;
    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic [DBC_W-1:0] r_dbc;
    logic [DBC_W-1:0] w_dbc_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             r_q_clean;
    logic             r_rise;
    logic             r_fall;
    logic             r_invalid;
    logic [CNT_W-1:0] r_set_count;

    sync_2ff u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (q_async),
        .o_q   (w_q_s)
    );

    sync_2ff u_sync_qbar (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (qbar_async),
        .o_q   (w_qbar_s)
    );

    assign w_valid = (w_q_s != w_qbar_s);

    // Any invalid or same-level sample aborts a check back to the stable state.
    always_comb begin
        w_state_nxt = r_state;
        w_dbc_nxt   = r_dbc;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        case (r_state)
            LOW: begin
                if (w_valid && w_q_s) begin
                    w_state_nxt = CHK_HIGH;
                    w_dbc_nxt   = DBC_W'(1);
                end
            end
            CHK_HIGH: begin
                if (!w_valid || !w_q_s) begin
                    w_state_nxt = LOW;
                    w_dbc_nxt   = '0;
                end else if (r_dbc == C_DBC_LAST) begin
                    w_state_nxt = HIGH;
                    w_dbc_nxt   = '0;
                    w_rise      = 1'b1;
                end else begin
                    w_dbc_nxt   = r_dbc + DBC_W'(1);
                end
            end
            HIGH: begin
                if (w_valid && !w_q_s) begin
                    w_state_nxt = CHK_LOW;
                    w_dbc_nxt   = DBC_W'(1);
                end
            end
            CHK_LOW: begin
                if (!w_valid || w_q_s) begin
                    w_state_nxt = HIGH;
                    w_dbc_nxt   = '0;
                end else if (r_dbc == C_DBC_LAST) begin
                    w_state_nxt = LOW;
                    w_dbc_nxt   = '0;
                    w_fall      = 1'b1;
                end else begin
                    w_dbc_nxt   = r_dbc + DBC_W'(1);
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_dbc_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LOW;
            r_dbc     <= '0;
            r_q_clean <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dbc     <= w_dbc_nxt;
            r_rise    <= w_rise;
            r_fall    <= w_fall;
            r_invalid <= ~w_valid;
            if (w_rise) begin
                r_q_clean <= 1'b1;
            end else if (w_fall) begin
                r_q_clean <= 1'b0;
            end
        end
    end

    // clr has priority over a coincident accepted edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set_count <= '0;
        end else if (clr) begin
            r_set_count <= '0;
        end else if (w_rise && (r_set_count != C_CNT_MAX)) begin
            r_set_count <= r_set_count + CNT_W'(1);
        end
    end

`ifdef SR_MON_FALL_COUNT_EN
    logic [CNT_W-1:0] r_reset_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reset_count <= '0;
        end else if (clr) begin
            r_reset_count <= '0;
        end else if (w_fall && (r_reset_count != C_CNT_MAX)) begin
            r_reset_count <= r_reset_count + CNT_W'(1);
        end
    end

    assign reset_count = r_reset_count;
`endif

    assign q_clean    = r_q_clean;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign invalid    = r_invalid;
    assign set_count  = r_set_count;

endmodule

`default_nettype wire
